regfile_bank: RTL and testbench



---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_word.sv | 18 +
 rtl/regfile_bank.sv | 47 ++++
 tb/tb_regfile_bank.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes and types for the architectural register file
package regfile_pkg;
  localparam int REG_WIDTH  = 32;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ZERO_REG   = 0;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_WIDTH-1:0]  reg_word_t;
endpackage

// File: rtl/regfile_word.sv
// regfile_word: one enabled register word with asynchronous active-low clear
module regfile_word
  import regfile_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_q <= '0;
    else if (i_en) r_q <= i_d;
  assign o_q = r_q;
endmodule

// File: rtl/regfile_bank.sv
// regfile_bank: register file with one synchronous write and two combinational reads
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int WIDTH  = REG_WIDTH,
  parameter int DEPTH  = REG_COUNT,
  parameter int BYPASS = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr1,
  output logic [WIDTH-1:0]         rd_data1,
  input  logic [$clog2(DEPTH)-1:0] rd_addr2,
  output logic [WIDTH-1:0]         rd_data2
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] w_words [DEPTH];
  logic [DEPTH-1:1] w_we;
  logic [WIDTH-1:0] w_rd1, w_rd2;
  assign w_words[ZERO_REG] = '0;
  for (genvar i = 1; i < DEPTH; i++) begin : g_word
    assign w_we[i] = wr_en && (wr_addr == AW'(i));
    regfile_word #(.WIDTH(WIDTH)) u_word (
      .clk  (clk),
      .rst_n(rst_n),
      .i_en (w_we[i]),
      .i_d  (wr_data),
      .o_q  (w_words[i])
    );
  end
  assign w_rd1 = w_words[rd_addr1];
  assign w_rd2 = w_words[rd_addr2];
  if (BYPASS != 0) begin : g_bypass
    // Forwarding never applies to r0 so it still reads zero.
    logic w_hit1, w_hit2;
    assign w_hit1   = wr_en && (wr_addr == rd_addr1) && (wr_addr != AW'(ZERO_REG));
    assign w_hit2   = wr_en && (wr_addr == rd_addr2) && (wr_addr != AW'(ZERO_REG));
    assign rd_data1 = w_hit1 ? wr_data : w_rd1;
    assign rd_data2 = w_hit2 ? wr_data : w_rd2;
  end else begin : g_direct
    assign rd_data1 = w_rd1;
    assign rd_data2 = w_rd2;
  end
endmodule

// File: tb/tb_regfile_bank.sv
// tb_regfile_bank: scoreboard bench driving a plain and a bypassing register file in parallel
module tb_regfile_bank;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr, rd_addr1, rd_addr2;
  logic [31:0] wr_data, rd_data1, rd_data2, rdb_data1, rdb_data2;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string       name;
    logic [31:0] e1, e2, eb1, eb2;
  } exp_t;
  exp_t q[$];
  event ev_chk;
  always #100 clk = ~clk;
  regfile_bank #(.BYPASS(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_data1(rd_data1), .rd_addr2(rd_addr2), .rd_data2(rd_data2)
  );
  regfile_bank #(.BYPASS(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_data1(rdb_data1), .rd_addr2(rd_addr2), .rd_data2(rdb_data2)
  );
  task automatic cmp(input string n, input string port, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %08h expected %08h", n, port, act, exp);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(ev_chk);
      while (q.size() > 0) begin
        e = q.pop_front();
        cmp(e.name, "plain_p1", rd_data1, e.e1);
        cmp(e.name, "plain_p2", rd_data2, e.e2);
        cmp(e.name, "bypass_p1", rdb_data1, e.eb1);
        cmp(e.name, "bypass_p2", rdb_data2, e.eb2);
      end
    end
  end
  task automatic chk(input string n, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [31:0] e1, input logic [31:0] e2,
                     input logic [31:0] eb1, input logic [31:0] eb2);
    exp_t e;
    rd_addr1 = a1;
    rd_addr2 = a2;
    #1;
    e.name = n; e.e1 = e1; e.e2 = e2; e.eb1 = eb1; e.eb2 = eb2;
    q.push_back(e);
    -> ev_chk;
    #1;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  initial begin
    logic [31:0] v;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr1 = '0; rd_addr2 = '0;
    chk("reset_init", 5'd1, 5'd31, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wr(5'd5, 32'hDEADBEEF);
    chk("r5_write", 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    chk("r4_r6_clean", 5'd4, 5'd6, 0, 0, 0, 0);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    chk("r0_pre", 5'd0, 5'd0, 0, 0, 0, 0);
    @(negedge clk);
    wr_en = 1'b0;
    chk("r0_post", 5'd0, 5'd0, 0, 0, 0, 0);
    wr(5'd7, 32'h11111111);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h22222222;
    chk("r7_pre", 5'd7, 5'd7, 32'h11111111, 32'h11111111, 32'h22222222, 32'h22222222);
    @(negedge clk);
    wr_en = 1'b0;
    chk("r7_post", 5'd7, 5'd7, 32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222);
    @(negedge clk);
    wr_en = 1'b0; wr_addr = 5'd9; wr_data = 32'hCAFEF00D;
    repeat (4) @(negedge clk);
    chk("r9_no_en", 5'd9, 5'd9, 0, 0, 0, 0);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h0000000A;
    chk("b2b_first", 5'd10, 5'd10, 0, 0, 32'h0000000A, 32'h0000000A);
    @(negedge clk);
    wr_data = 32'h0000000B;
    chk("b2b_second", 5'd10, 5'd10, 32'h0000000A, 32'h0000000A, 32'h0000000B, 32'h0000000B);
    @(negedge clk);
    wr_data = 32'h0000000C;
    chk("b2b_third", 5'd10, 5'd10, 32'h0000000B, 32'h0000000B, 32'h0000000C, 32'h0000000C);
    @(negedge clk);
    wr_en = 1'b0;
    chk("b2b_last", 5'd10, 5'd10, 32'h0000000C, 32'h0000000C, 32'h0000000C, 32'h0000000C);
    for (int k = 1; k < 32; k++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'(k); wr_data = 32'h1000 + 32'(k);
    end
    @(negedge clk);
    wr_en = 1'b0;
    for (int k = 0; k < 32; k++) begin
      logic [31:0] v1, v2;
      v1 = (k == 0) ? 32'h0 : 32'h1000 + 32'(k);
      v2 = (k == 31) ? 32'h0 : 32'h1000 + 32'(31 - k);
      chk($sformatf("fill_pair_%0d", k), 5'(k), 5'(31 - k), v1, v2, v1, v2);
    end
    @(negedge clk);
    #10 rst_n = 1'b0;
    for (int k = 0; k < 32; k++)
      chk($sformatf("async_clear_%0d", k), 5'(k), 5'(31 - k), 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h12345678;
    @(negedge clk);
    wr_en = 1'b0;
    chk("reset_beats_write", 5'd3, 5'd3, 0, 0, 0, 0);
    rst_n = 1'b1;
    wr(5'd3, 32'h87654321);
    chk("write_after_reset", 5'd3, 5'd0, 32'h87654321, 0, 32'h87654321, 0);
    for (int i = 0; i < 100 && q.size() > 0; i++) #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    v = 32'(checks);
    $display("Simulation finished: %0d checks, %0d errors", v, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1);
  end
endmodule
